// File: rtl/adc_serie_lector.sv
// Serial reader for an 8-bit SPI-style ADC: periodic CS/SCLK framing, MSB-first capture.
// Optional ADC_PROMEDIO_EN: deliver the mean of every 4 conversions instead of each one.
module adc_serie_lector #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned LEAD_BITS     = 1,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iEnable,
  input  logic       iMISO,
  output logic       oCS_n,
  output logic       oSCLK,
  output logic [7:0] ovDatos,
  output logic       oDatoValido,
  output logic       oBusy
);
  localparam int unsigned NBits = LEAD_BITS + 8;
  localparam int unsigned PerW  = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RiseW = $clog2(NBits + 1);
  localparam logic [PerW-1:0]  PerLast  = PerW'(SAMPLE_PERIOD - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [RiseW-1:0] RiseLead = RiseW'(LEAD_BITS);
  localparam logic [RiseW-1:0] RiseLast = RiseW'(NBits);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_e;

  state_e           stateQ, stateD;
  logic [PerW-1:0]  periodQ, periodD;
  logic [DivW-1:0]  divQ, divD;
  logic [RiseW-1:0] riseQ, riseD;
  logic [7:0]       shiftQ, shiftD;
  logic [7:0]       datosQ, datosD;
  logic             csQ, csD, sclkQ, sclkD, validQ, validD, busyQ, busyD;
  logic             start;
`ifdef ADC_PROMEDIO_EN
  logic [9:0]       accQ, accD, sum;
  logic [1:0]       cntQ, cntD;
`endif

  assign start = iEnable && (periodQ == PerLast) && (stateQ == StIdle);

  always_comb begin
    stateD  = stateQ;
    periodD = periodQ;
    divD    = divQ;
    riseD   = riseQ;
    shiftD  = shiftQ;
    datosD  = datosQ;
    csD     = csQ;
    sclkD   = sclkQ;
    busyD   = busyQ;
    validD  = 1'b0;
`ifdef ADC_PROMEDIO_EN
    accD    = accQ;
    cntD    = cntQ;
    sum     = accQ + {2'b00, shiftQ};
`endif

    if (!iEnable) begin
      periodD = '0;
    end else if (periodQ == PerLast) begin
      periodD = '0;
    end else begin
      periodD = periodQ + PerW'(1);
    end

    unique case (stateQ)
      StIdle: begin
        csD   = 1'b1;
        sclkD = 1'b0;
        busyD = 1'b0;
`ifdef ADC_PROMEDIO_EN
        if (!iEnable) begin
          accD = '0;
          cntD = '0;
        end
`endif
        if (start) begin
          stateD = StSetup;
          csD    = 1'b0;
          busyD  = 1'b1;
          divD   = '0;
          riseD  = '0;
          shiftD = '0;
        end
      end
      StSetup: begin
        if (divQ == DivLast) begin
          divD   = '0;
          stateD = StShift;
        end else begin
          divD = divQ + DivW'(1);
        end
      end
      StShift: begin
        if (divQ == DivLast) begin
          divD  = '0;
          sclkD = ~sclkQ;
          if (!sclkQ) begin
            riseD = riseQ + RiseW'(1);
            // Leading rises carry start/mux bits and are not captured.
            if (riseQ >= RiseLead) shiftD = {shiftQ[6:0], iMISO};
          end else if (riseQ == RiseLast) begin
            stateD = StDone;
            csD    = 1'b1;
            busyD  = 1'b0;
          end
        end else begin
          divD = divQ + DivW'(1);
        end
      end
      StDone: begin
        stateD = StIdle;
`ifdef ADC_PROMEDIO_EN
        if (cntQ == 2'd3) begin
          datosD = sum[9:2];
          validD = 1'b1;
          accD   = '0;
          cntD   = '0;
        end else begin
          accD = sum;
          cntD = cntQ + 2'd1;
        end
`else
        datosD = shiftQ;
        validD = 1'b1;
`endif
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      stateQ  <= StIdle;
      periodQ <= '0;
      divQ    <= '0;
      riseQ   <= '0;
      shiftQ  <= '0;
      datosQ  <= '0;
      csQ     <= 1'b1;
      sclkQ   <= 1'b0;
      validQ  <= 1'b0;
      busyQ   <= 1'b0;
`ifdef ADC_PROMEDIO_EN
      accQ    <= '0;
      cntQ    <= '0;
`endif
    end else begin
      stateQ  <= stateD;
      periodQ <= periodD;
      divQ    <= divD;
      riseQ   <= riseD;
      shiftQ  <= shiftD;
      datosQ  <= datosD;
      csQ     <= csD;
      sclkQ   <= sclkD;
      validQ  <= validD;
      busyQ   <= busyD;
`ifdef ADC_PROMEDIO_EN
      accQ    <= accD;
      cntQ    <= cntD;
`endif
    end
  end

  assign oCS_n       = csQ;
  assign oSCLK       = sclkQ;
  assign ovDatos     = datosQ;
  assign oDatoValido = validQ;
  assign oBusy       = busyQ;
endmodule

// File: doc/adc_serie_lector.md
# adc_serie_lector

Serial front-end for the spirometer's 8-bit SPI-style ADC. Generates chip-select and serial clock, shifts in one conversion MSB-first, and presents the byte with a one-cycle valid strobe. Conversions are triggered periodically. `ovDatos` feeds the flow-scaling stage directly, and `oDatoValido` drives that stage's clock enable.

## Interface
- `CLK_DIV`, default 4: `iClk` cycles per `oSCLK` half-period; must be ≥1.
- `LEAD_BITS`, default 1: leading SCLK cycles per frame whose data is discarded (start/mux-settle bits).
- `SAMPLE_PERIOD`, default 1000: `iClk` cycles between frame starts; must be > 2·CLK_DIV·(LEAD_BITS+8)+CLK_DIV+2.
- `iClk` in 1: system clock; all logic on rising edge.
- `iReset_n` in 1: asynchronous, active-low reset.
- `iEnable` in 1: periodic sampling enable.
- `iMISO` in 1: serial data from ADC.
- `oCS_n` out 1: ADC chip select, active low.
- `oSCLK` out 1: ADC serial clock, idle low.
- `ovDatos` out 8: last conversion result, held between updates.
- `oDatoValido` out 1: one-`iClk` pulse when `ovDatos` updates.
- `oBusy` out 1: high while a frame is in progress (`oCS_n`=0).

## Operation
- All outputs are registered. Reset values: `oCS_n`=1, `oSCLK`=0, `ovDatos`=0, `oDatoValido`=0, `oBusy`=0. Internal counters and the shift register are 0 and the FSM is in IDLE.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while `iEnable`=1.
  - Is forced to 0 while `iEnable`=0.
  - A frame starts when the counter equals SAMPLE_PERIOD-1, `iEnable`=1, and the FSM is in IDLE. A start that occurs while the FSM is not in IDLE is dropped, not queued.
- FSM states:
  - IDLE: `oCS_n`=1, `oSCLK`=0. On a start, go to SETUP; `oCS_n`=0 and `oBusy`=1 from the next cycle.
  - SETUP: hold CLK_DIV cycles with `oSCLK`=0 (CS-to-SCLK setup), then go to SHIFT.
  - SHIFT:
    - `oSCLK` toggles every CLK_DIV cycles, starting low.
    - On each 0→1 toggle, the rise index increments. If index ≥ LEAD_BITS, the current `iMISO` is shifted into the LSB of the 8-bit shift register (MSB arrives first).
    - After N = LEAD_BITS+8 rising edges, the following falling edge moves the FSM to DONE.
  - DONE (1 cycle): `oCS_n`=1, `oBusy`=0, `ovDatos` ← shift register, `oDatoValido`=1 on the next cycle. Return to IDLE.
- Deasserting `iEnable` mid-frame does not abort; the frame completes and delivers its byte.
- Asserting `iReset_n` low mid-frame immediately returns all outputs to their reset values. No partial byte is delivered.
- `iMISO` is consumed only at the sampling points above; it is ignored at all other times.

## Timing
- Frame start (first cycle `oCS_n`=0) to `oDatoValido` high: CLK_DIV + 2·CLK_DIV·N + 1 cycles. Defaults: 4+72+1 = 77.
- `oCS_n` low duration: CLK_DIV + 2·CLK_DIV·N cycles (76 at defaults).
- `oSCLK` period: 2·CLK_DIV cycles, 50% duty cycle; exactly N rising edges per frame.
- Consecutive frame starts are exactly SAMPLE_PERIOD cycles apart while `iEnable` stays high.
- First frame starts SAMPLE_PERIOD cycles after `iEnable` rises, or after reset release with `iEnable` high.

## Configuration
- `ADC_PROMEDIO_EN` defined:
  - A 10-bit accumulator sums 4 consecutive conversions.
  - On the 4th conversion, `ovDatos` = sum[9:2] and `oDatoValido` pulses. The accumulator and the 2-bit count then clear.
  - Conversions 1–3 produce no pulse and leave `ovDatos` unchanged.
  - `iEnable`=0 while in IDLE clears the accumulator and count.
  - Latency from the 4th frame's start equals the undefined-case latency.
- Undefined: every conversion updates `ovDatos` and pulses `oDatoValido`. No accumulator is synthesized.

## Test plan
- Defaults, ADC model drives lead bit 0 then 0xA5 MSB-first, changing data on SCLK falling edges → `ovDatos`=0xA5, `oDatoValido` pulses 77 cycles after `oCS_n` falls, 9 SCLK rises observed.
- `iEnable` held high for 3500 cycles → `oCS_n` falls at cycles 1000, 2000 and 3000 after enable; 3 pulses.
- ADC model returns 0x00 then 0xFF → `ovDatos` = 0x00, then 0xFF; lead bit driven 1 is discarded.
- `iReset_n` pulsed low 30 cycles into a frame → `oCS_n`=1, `oSCLK`=0, `ovDatos`=0 immediately; no pulse. The next frame starts SAMPLE_PERIOD cycles after reset release.
- `iEnable` dropped 20 cycles into a frame → frame completes and byte is delivered; no further `oCS_n` falls.
- `ADC_PROMEDIO_EN`, conversions 0x10, 0x20, 0x30, 0x41 → single pulse after the 4th with `ovDatos`=0x28; no pulses after the first three.
